regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor to the 32x32 two-read/one-write register file. Adds a self-clearing init sequencer with a programmable stack-pointer reset value and a per-register busy scoreboard for multi-cycle producers such as load and MUL. It also adds a hardwired-zero option and optional write-to-read bypass. It sits between decode (read ports) and writeback (write port) in the core datapath.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
SP_IDX, 29, index of the stack-pointer register
SP_INIT, 252, value loaded into SP_IDX by the init sequence (truncated to DATA_W)
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and busy-set

Ports:
elk  in  1  clock, all state updates on rising edge
nrst  in  1  reset, synchronous, active-high (1 = reset)
init_done  out  1  1 once the init sweep completes
wr_en  in  1  write strobe
wr_addr  in  ADDR_W  write index
wr_data  in  DATA_W  write data
bsy_set  in  1  mark bsy_addr as having a pending producer
bsy_addr  in  ADDR_W  index to mark busy
rd_addrA  in  ADDR_W  read port A index
rd_dataA  out  DATA_W  read port A data (combinational)
rd_validA  out  1  1 = rd_dataA not pending
rd_addrB  in  ADDR_W  read port B index
rd_dataB  out  DATA_W  read port B data (combinational)
rd_validB  out  1  1 = rd_dataB not pending

Behaviour:
- FSM has two states: INIT and RUN. nrst=1 at an edge forces INIT, sweep counter idx=0, all busy bits=0, and init_done=0. Reset takes priority over every other input.
- INIT, one register per cycle:
  - Writes reg[idx] = 0, or SP_INIT when idx==SP_IDX.
  - idx increments each cycle.
  - After writing idx = 2**ADDR_W-1, the FSM moves to RUN and init_done=1 on the following cycle.
  - Sweep lasts exactly 2**ADDR_W cycles after reset deasserts.
- During INIT:
  - wr_en and bsy_set are ignored.
  - rd_dataA/B = 0 and rd_validA/B = 0.
- Reset asserted mid-sweep or in RUN restarts the sweep from idx 0.
- RUN, writes:
  - wr_en=1 writes reg[wr_addr]=wr_data at the edge and clears busy[wr_addr].
- RUN, busy-set:
  - bsy_set=1 sets busy[bsy_addr].
  - Same edge, same address as a write: the data is written and busy ends 1 (the new producer wins).
- RUN, reads:
  - rd_dataX = reg[rd_addrX].
  - rd_validX = ~busy[rd_addrX].
  - Asynchronous, zero latency.
- ZERO_REG=1:
  - Writes and bsy_set to index 0 are dropped.
  - Reads of index 0 return 0 with valid=1.
  - INIT still writes reg 0.
- Read during the write cycle without bypass: the old value and old valid are returned; the new value appears after the edge.
- SP_IDX is an ordinary register after INIT and can be written.
- No output is registered except init_done, the busy bits and the array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in RUN, if wr_en=1 and rd_addrX==wr_addr (excluding index 0 when ZERO_REG=1), then rd_dataX=wr_data and rd_validX=1 in the same cycle.
  - Exception: if bsy_set targets the same address in that cycle, rd_validX=0.
- Undefined: no forwarding; reads see the array only; the bypass logic is absent.

Test Plan:
- Reset and sweep:
  - Stimulus: nrst=1 for 2 cycles, then 0.
  - Required: init_done rises exactly 32 cycles later, reg29 reads 252 (0xFC), every other register reads 0, all valid=1.
- Reset mid-sweep:
  - Stimulus: after init_done, write reg5=0xDEADBEEF; assert nrst at sweep idx 10; release.
  - Required: init_done stays 0 for a full 32 cycles again; reg5 reads 0.
- Scoreboard:
  - Stimulus: bsy_set reg7; next cycle rd_addrA=7.
  - Required: rd_validA=0. After wr_en reg7=0x1234, rd_dataA=0x1234 and rd_validA=1.
  - Stimulus: simultaneous bsy_set and write to reg7.
  - Required: busy stays 1.
- Zero register:
  - Stimulus: write reg0=0xFFFFFFFF plus bsy_set reg0.
  - Required: rd_dataB=0, rd_validB=1.
- Writes during INIT:
  - Stimulus: wr_en with reg3=0x55 at sweep idx 1.
  - Required: reg3=0 after the sweep.
- Bypass (REGFILE_BYPASS_EN defined):
  - Stimulus: wr_en reg12=0xA5A5A5A5 with rd_addrA=12 in the same cycle.
  - Required: rd_dataA=0xA5A5A5A5 in that cycle. With the macro undefined, the prior value is returned in that cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with an init sweep
// (stack pointer preset), a per-register busy scoreboard and an optional
// hardwired zero register.
// Optional feature macro: REGFILE_BYPASS_EN forwards the write port to the
// read ports in the same cycle.
module regfile_sb #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned SP_IDX   = 29,
   parameter int unsigned SP_INIT  = 252,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              elk,
   input  logic              nrst,
   output logic              init_done,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              bsy_set,
   input  logic [ADDR_W-1:0] bsy_addr,
   input  logic [ADDR_W-1:0] rd_addrA,
   output logic [DATA_W-1:0] rd_dataA,
   output logic              rd_validA,
   input  logic [ADDR_W-1:0] rd_addrB,
   output logic [DATA_W-1:0] rd_dataB,
   output logic              rd_validB
);

   localparam int unsigned       DEPTH  = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);
   localparam logic [ADDR_W-1:0] SP_A   = ADDR_W'(SP_IDX);
   localparam logic              ZR     = (ZERO_REG != 0);

   typedef enum logic {INIT, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_ok;
   logic              bsy_ok;

   // Writes and busy-sets to register 0 are dropped when it is hardwired.
   assign wr_ok  = wr_en   && !(ZR && (wr_addr  == '0));
   assign bsy_ok = bsy_set && !(ZR && (bsy_addr == '0));

   // Scoreboard update: a write retires the producer, a same-edge set wins.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok)  busy_nxt[wr_addr]  = 1'b0;
      if (bsy_ok) busy_nxt[bsy_addr] = 1'b1;
   end

   // Sequencer: reset restarts the sweep, INIT walks every index, RUN tracks busy.
   always_ff @(posedge elk) begin
      if (nrst) begin
         state     <= INIT;
         idx       <= '0;
         init_done <= 1'b0;
         busy      <= '0;
      end else if (state == INIT) begin
         idx <= idx + ADDR_W'(1);
         if (idx == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
         end
      end else begin
         busy <= busy_nxt;
      end
   end

   // Array: the sweep owns the write port during INIT, writeback owns it in RUN.
   always_ff @(posedge elk) begin
      if (!nrst) begin
         if (state == INIT)
            mem[idx] <= (idx == SP_A) ? SP_VAL : '0;
         else if (wr_ok)
            mem[wr_addr] <= wr_data;
      end
   end

   // Read port A: blanked during INIT, zero register, optional forwarding.
   always_comb begin
      rd_dataA  = '0;
      rd_validA = 1'b0;
      if (state == RUN) begin
         rd_dataA  = mem[rd_addrA];
         rd_validA = ~busy[rd_addrA];
         if (ZR && (rd_addrA == '0)) begin
            rd_dataA  = '0;
            rd_validA = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_ok && (rd_addrA == wr_addr)) begin
            rd_dataA  = wr_data;
            rd_validA = ~(bsy_ok && (bsy_addr == wr_addr));
         end
`endif
      end
   end

   // Read port B: same behaviour as port A.
   always_comb begin
      rd_dataB  = '0;
      rd_validB = 1'b0;
      if (state == RUN) begin
         rd_dataB  = mem[rd_addrB];
         rd_validB = ~busy[rd_addrB];
         if (ZR && (rd_addrB == '0)) begin
            rd_dataB  = '0;
            rd_validB = 1'b1;
         end
`ifdef REGFILE_BYPASS_EN
         else if (wr_ok && (rd_addrB == wr_addr)) begin
            rd_dataB  = wr_data;
            rd_validB = ~(bsy_ok && (bsy_addr == wr_addr));
         end
`endif
      end
   end

endmodule
